// File: rtl/usb_frame_timer_if.sv
// Host-port framing bundle between the frame timer (master) and the packet engine (slave).
interface usb_frame_timer_if;
    logic        enable;
    logic        sof_ack;
    logic        clr_missed;
    logic        sof_req;
    logic [10:0] frame_num;
    logic        frame_tick;
    logic        eof_guard;
    logic        missed_sof;

    modport master (
        input  enable, sof_ack, clr_missed,
        output sof_req, frame_num, frame_tick, eof_guard, missed_sof
    );

    modport slave (
        output enable, sof_ack, clr_missed,
        input  sof_req, frame_num, frame_tick, eof_guard, missed_sof
    );
endinterface

// File: rtl/usb_frame_timer.sv
// USB full-speed 1 ms frame timer: SOF request/ack tracking, frame numbering, EOF guard window.
// Define USB_FRAME_TRIM_EN to add a 4-bit two's-complement trim port that adjusts each frame length.
module usb_frame_timer #(
    parameter int FRAME_LEN = 12000,
    parameter int EOF_GUARD = 600
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef USB_FRAME_TRIM_EN
    input  logic [3:0]        trim,
`endif
    usb_frame_timer_if.master bus
);

    // Headroom of 8 keeps FRAME_LEN-8 .. FRAME_LEN+7 representable for any trim value.
    localparam int CW = $clog2(FRAME_LEN + 8);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] start_len;
    logic [10:0]   num_q, num_d;
    logic          sof_req_q, sof_req_d;
    logic          tick_q, tick_d;
    logic          guard_q, guard_d;
    logic          missed_q, missed_d;

    // Length of a frame that begins at this edge; latched so trim may change mid-frame.
`ifdef USB_FRAME_TRIM_EN
    assign start_len = CW'(FRAME_LEN) + {{(CW-4){trim[3]}}, trim};
`else
    assign start_len = CW'(FRAME_LEN);
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        num_d     = num_q;
        sof_req_d = sof_req_q;
        tick_d    = 1'b0;
        missed_d  = missed_q;

        if (bus.clr_missed) begin
            missed_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                sof_req_d = 1'b0;
                if (bus.enable) begin
                    state_d   = RUN;
                    tick_d    = 1'b1;
                    sof_req_d = 1'b1;
                    len_d     = start_len;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    sof_req_d = 1'b0;
                end else if (cnt_q == len_q - CW'(1)) begin
                    // Frame boundary: an ack arriving here is for the old frame, the new SOF stays pending.
                    cnt_d     = '0;
                    num_d     = num_q + 11'd1;
                    tick_d    = 1'b1;
                    sof_req_d = 1'b1;
                    len_d     = start_len;
                    if (sof_req_q && !bus.sof_ack) begin
                        missed_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (bus.sof_ack) begin
                        sof_req_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Derived from the next count so the registered flag lines up with cnt.
        guard_d = (state_d == RUN) && (cnt_d >= len_d - CW'(EOF_GUARD));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= CW'(FRAME_LEN);
            num_q     <= '0;
            sof_req_q <= 1'b0;
            tick_q    <= 1'b0;
            guard_q   <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            num_q     <= num_d;
            sof_req_q <= sof_req_d;
            tick_q    <= tick_d;
            guard_q   <= guard_d;
            missed_q  <= missed_d;
        end
    end

    assign bus.sof_req    = sof_req_q;
    assign bus.frame_num  = num_q;
    assign bus.frame_tick = tick_q;
    assign bus.eof_guard  = guard_q;
    assign bus.missed_sof = missed_q;

endmodule

// File: doc/usb_frame_timer.md
USB_FRAME_TIMER -- requirements
Module: usb_frame_timer

Interface
REQ-001 SHALL provide parameter FRAME_LEN, default 12000, clock cycles per 1 ms USB frame at 12 MHz.
REQ-002 SHALL provide parameter EOF_GUARD, default 600, cycles at frame end during which no new transaction may start.
REQ-003 SHALL provide port clk  input  1  12 MHz clock from the PLL clkout0; the block's only clock.
REQ-004 SHALL provide port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL provide port enable  input  1  host port active; starts and stops framing.
REQ-006 SHALL provide port sof_ack  input  1  packet engine has taken the pending SOF.
REQ-007 SHALL provide port clr_missed  input  1  clears the missed_sof flag.
REQ-008 SHALL provide port sof_req  output  1  SOF token pending for the current frame.
REQ-009 SHALL provide port frame_num  output  11  frame number carried by the pending or current SOF.
REQ-010 SHALL provide port frame_tick  output  1  one-cycle pulse at each frame start.
REQ-011 SHALL provide port eof_guard  output  1  high inside the end-of-frame guard window.
REQ-012 SHALL provide port missed_sof  output  1  sticky flag: a frame started while the previous SOF was unacknowledged.

Function
REQ-013 SHALL implement two states, IDLE and RUN; all outputs SHALL be registered.
REQ-014 In IDLE: cycle counter cnt = 0; sof_req, frame_tick and eof_guard = 0; frame_num holds.
REQ-015 IDLE with enable=1 at an edge SHALL enter RUN at that edge, with cnt=0, frame_tick=1, sof_req=1, and frame_num unchanged.
REQ-016 In RUN, cnt SHALL increment by 1 per cycle over 0..FRAME_LEN-1.
REQ-017 At an edge where cnt==FRAME_LEN-1, cnt SHALL wrap to 0, frame_num SHALL increment, frame_tick SHALL be 1 for one cycle, and sof_req SHALL be set; frame period = FRAME_LEN cycles exactly.
REQ-018 frame_num SHALL wrap from 2047 to 0.
REQ-019 sof_ack sampled while sof_req=1 and no wrap occurs SHALL clear sof_req at the next edge; sof_ack while sof_req=0 SHALL be ignored.
REQ-020 A wrap while sof_req=1 and sof_ack=0 SHALL set missed_sof; sof_req SHALL stay 1, carrying the new frame_num.
REQ-021 A wrap coinciding with sof_ack SHALL leave sof_req=1 for the new frame and SHALL NOT set missed_sof.
REQ-022 eof_guard SHALL be 1 exactly while cnt >= FRAME_LEN-EOF_GUARD (registered, aligned to cnt), and 0 in IDLE.
REQ-023 missed_sof SHALL clear on clr_missed; a set event in the same cycle SHALL take priority.
REQ-024 enable=0 in RUN SHALL return to IDLE at the next edge, clearing cnt, sof_req, frame_tick and eof_guard; frame_num and missed_sof SHALL hold.
REQ-025 Counter width SHALL be ceil(log2(FRAME_LEN+8)) bits; no overflow for any legal FRAME_LEN (>= EOF_GUARD+16).

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE, cnt=0, frame_num=0, and sof_req, frame_tick, eof_guard and missed_sof all 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no frame_tick; it SHALL override enable, sof_ack and clr_missed.

Configuration
REQ-028 With macro USB_FRAME_TRIM_EN defined, the block SHALL add port trim (input, 4 bits, two's complement); each frame length SHALL be FRAME_LEN+trim, with trim sampled at every frame start (REQ-015/REQ-017).
REQ-029 With USB_FRAME_TRIM_EN undefined, port trim SHALL be absent and the frame length SHALL be fixed at FRAME_LEN.

Verification
REQ-030 Reset, enable=1 held, sof_ack pulsed 3 cycles after each sof_req -> frame_tick every 12000 cycles, frame_num 0,1,2,..., missed_sof=0.
REQ-031 frame_num preset to 2047 by running 2047 frames (FRAME_LEN overridden to 32 for speed), one more wrap -> frame_num=0.
REQ-032 sof_ack never asserted -> missed_sof=1 after the second frame_tick, sof_req continuously 1; clr_missed pulse -> missed_sof=0 until the next wrap.
REQ-033 sof_ack asserted exactly on the cycle cnt==11999 -> sof_req stays 1 into the new frame, missed_sof stays 0.
REQ-034 Check eof_guard -> rises when cnt=11400, falls when cnt=0; enable dropped at cnt=5000 -> IDLE next cycle, frame_num held; rst_n=0 at cnt=7000 -> all outputs 0 and frame_num=0.
REQ-035 With USB_FRAME_TRIM_EN, trim=-3 -> 11997-cycle frames; trim=+7 -> 12007-cycle frames.
